// File: rtl/cpu_mem_arbiter.sv
// Two-requester sram-like arbiter (fetch + load/store) onto one memory port.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default is data priority.
module cpu_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [2:0] {
    IDLE,
    INST_ADDR,
    INST_WAIT,
    DATA_ADDR,
    DATA_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grant_data;
  logic        grant_inst;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q: 1 = data side won the previous grant
  logic last_q, last_d;

  assign grant_data = data_req && !(inst_req && last_q);
  assign grant_inst = inst_req && !grant_data;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE) begin
      if (grant_data)      last_d = 1'b1;
      else if (grant_inst) last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
  end
`else
  assign grant_data = data_req;
  assign grant_inst = inst_req && !data_req;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = DATA_ADDR;
          wr_d    = data_wr;
          size_d  = data_size;
          addr_d  = data_addr;
          wdata_d = data_wdata;
        end else if (grant_inst) begin
          state_d = INST_ADDR;
          wr_d    = 1'b0;
          size_d  = inst_size;
          addr_d  = inst_addr;
          wdata_d = '0;
        end
      end
      INST_ADDR: if (mem_addr_ok) state_d = INST_WAIT;
      INST_WAIT: if (mem_data_ok) state_d = IDLE;
      DATA_ADDR: if (mem_addr_ok) state_d = DATA_WAIT;
      DATA_WAIT: if (mem_data_ok) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req   = (state_q == INST_ADDR) || (state_q == DATA_ADDR);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Handshakes are gated by ownership so the idle side never sees a pulse
  assign inst_addr_ok = (state_q == INST_ADDR) && mem_addr_ok;
  assign data_addr_ok = (state_q == DATA_ADDR) && mem_addr_ok;
  assign inst_data_ok = (state_q == INST_WAIT) && mem_data_ok;
  assign data_data_ok = (state_q == DATA_WAIT) && mem_data_ok;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: requester drivers, memory model,
// and a monitor popping expected grants in order.
module tb_cpu_mem_arbiter;

  typedef struct packed {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   addr_lat = 0;
  int   data_lat = 0;
  int   inj_n = 0;
  txn_t inst_cmd_q[$];
  txn_t data_cmd_q[$];
  txn_t exp_q[$];
  int   aok_cyc_q[$];
  txn_t cur;
  logic cur_v = 1'b0;
  int   dok_cyc = 0;
  int   n_idok = 0;
  int   n_ddok = 0;
  logic [31:0] last_irdata = '0;
  logic i_busy = 1'b0;
  logic d_busy = 1'b0;
  int   i_issue = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_0001;
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic txn_t mk(input logic d, input logic w,
                              input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] wd);
    txn_t t;
    t.is_data = d;
    t.wr      = w;
    t.size    = s;
    t.addr    = a;
    t.wdata   = wd;
    return t;
  endfunction

  task automatic post(input txn_t t);
    if (t.is_data) data_cmd_q.push_back(t);
    else           inst_cmd_q.push_back(t);
  endtask

  // instruction-fetch requester: holds req until addr_ok
  initial begin
    txn_t t;
    logic acc;
    inst_req = 0; inst_size = 0; inst_addr = 0;
    forever begin
      @(negedge clk);
      acc = i_busy && inst_addr_ok;
      @(posedge clk); #1;
      if (acc || reset) begin inst_req = 0; i_busy = 0; end
      if (!i_busy && !reset && inst_cmd_q.size() > 0) begin
        t = inst_cmd_q.pop_front();
        inst_req = 1; inst_size = t.size; inst_addr = t.addr;
        i_busy = 1; i_issue = cyc;
      end
    end
  end

  // load/store requester
  initial begin
    txn_t t;
    logic acc;
    data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0;
    forever begin
      @(negedge clk);
      acc = d_busy && data_addr_ok;
      @(posedge clk); #1;
      if (acc || reset) begin data_req = 0; d_busy = 0; end
      if (!d_busy && !reset && data_cmd_q.size() > 0) begin
        t = data_cmd_q.pop_front();
        data_req = 1; data_wr = t.wr; data_size = t.size;
        data_addr = t.addr; data_wdata = t.wdata;
        d_busy = 1;
      end
    end
  end

  // sram-like memory with programmable address/data latency
  initial begin
    int phase, cnt, inj_done;
    logic [31:0] a;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    phase = 0; cnt = 0; inj_done = 0; a = 0;
    forever begin
      @(posedge clk); #1;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      if (reset) begin
        phase = 0; cnt = 0;
      end else if (inj_n != inj_done) begin
        inj_done++;
        mem_data_ok = 1; mem_rdata = 32'h0BAD_0BAD;
      end else if (phase == 0) begin
        if (mem_req) begin
          if (cnt >= addr_lat) begin
            mem_addr_ok = 1; a = mem_addr; phase = 1; cnt = 0;
          end else cnt++;
        end
      end else begin
        if (cnt >= data_lat) begin
          mem_data_ok = 1; mem_rdata = rd_of(a); phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // monitor: pops the expected grant on addr_ok, checks data on data_ok
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (reset) cur_v = 1'b0;
      else begin
        if (mem_req && exp_q.size() > 0)
          chk("mem_addr_hold", mem_addr, exp_q[0].addr);
        if (inst_addr_ok || data_addr_ok) begin
          aok_cyc_q.push_back(cyc);
          chk("aok_needs_mem", {31'b0, mem_addr_ok}, 32'd1);
          if (exp_q.size() == 0)
            chk("spurious_aok", {30'b0, inst_addr_ok, data_addr_ok}, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("aok_owner", {30'b0, inst_addr_ok, data_addr_ok},
                e.is_data ? 32'd1 : 32'd2);
            chk("mem_wr", {31'b0, mem_wr}, {31'b0, e.wr});
            chk("mem_size", {30'b0, mem_size}, {30'b0, e.size});
            chk("mem_wdata", mem_wdata, e.wdata);
            cur = e; cur_v = 1'b1;
          end
        end
        if (inst_data_ok || data_data_ok) begin
          if (!cur_v)
            chk("spurious_dok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
          else begin
            chk("dok_owner", {30'b0, inst_data_ok, data_data_ok},
                cur.is_data ? 32'd1 : 32'd2);
            chk("owner_rdata", cur.is_data ? data_rdata : inst_rdata,
                rd_of(cur.addr));
            chk("other_rdata", cur.is_data ? inst_rdata : data_rdata, 32'd0);
            cur_v = 1'b0; dok_cyc = cyc;
            if (inst_data_ok) begin n_idok++; last_irdata = inst_rdata; end
            if (data_data_ok) n_ddok++;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !cur_v && !i_busy && !d_busy &&
          inst_cmd_q.size() == 0 && data_cmd_q.size() == 0) break;
    end
    chk("drain", exp_q.size() + inst_cmd_q.size() + data_cmd_q.size()
        + int'(cur_v), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b, ni, nd;
    txn_t t;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_size", {30'b0, mem_size}, 32'd0);
    chk("rst_oks", {28'b0, inst_addr_ok, inst_data_ok,
                    data_addr_ok, data_data_ok}, 32'd0);
    #2 reset = 1'b0;

    // single fetch, data returned two cycles after acceptance
    addr_lat = 0; data_lat = 1; ni = n_idok; nd = n_ddok;
    t = mk(0, 0, 2'd2, 32'hBFC0_0000, 32'd0);
    exp_q.push_back(t); post(t);
    wait_idle(50);
    chk("fetch_dok_count", n_idok - ni, 32'd1);
    chk("fetch_rdata", last_irdata, 32'h3C08_0001);
    chk("fetch_no_data_dok", n_ddok - nd, 32'd0);

    // store and fetch together: store wins, fetch after store completes
    t = mk(1, 1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF);
    exp_q.push_back(t); post(t);
    t = mk(0, 0, 2'd2, 32'hBFC0_0004, 32'd0);
    exp_q.push_back(t); post(t);
    wait_idle(50);

    // zero-wait fetch takes grant + address + data = 3 cycles
    addr_lat = 0; data_lat = 0;
    t = mk(0, 0, 2'd2, 32'hBFC0_0008, 32'd0);
    exp_q.push_back(t); post(t);
    wait_idle(50);
    chk("min_latency", dok_cyc - i_issue, 32'd2);

    // both sides requesting continuously
    b = aok_cyc_q.size();
    for (int i = 0; i < 3; i++)
      post(mk(1, 0, 2'd2, 32'h8000_0100 + 32'(i * 4), 32'd0));
    for (int i = 0; i < 2; i++)
      post(mk(0, 0, 2'd2, 32'hBFC0_0100 + 32'(i * 4), 32'd0));
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk(1, 0, 2'd2, 32'h8000_0100, 32'd0));
    exp_q.push_back(mk(0, 0, 2'd2, 32'hBFC0_0100, 32'd0));
    exp_q.push_back(mk(1, 0, 2'd2, 32'h8000_0104, 32'd0));
    exp_q.push_back(mk(0, 0, 2'd2, 32'hBFC0_0104, 32'd0));
    exp_q.push_back(mk(1, 0, 2'd2, 32'h8000_0108, 32'd0));
`else
    exp_q.push_back(mk(1, 0, 2'd2, 32'h8000_0100, 32'd0));
    exp_q.push_back(mk(1, 0, 2'd2, 32'h8000_0104, 32'd0));
    exp_q.push_back(mk(1, 0, 2'd2, 32'h8000_0108, 32'd0));
    exp_q.push_back(mk(0, 0, 2'd2, 32'hBFC0_0100, 32'd0));
    exp_q.push_back(mk(0, 0, 2'd2, 32'hBFC0_0104, 32'd0));
`endif
    wait_idle(100);
    chk("b2b_grants", aok_cyc_q.size() - b, 32'd5);
    if (aok_cyc_q.size() - b == 5) begin
      chk("b2b_gap_first", aok_cyc_q[b+1] - aok_cyc_q[b], 32'd3);
      chk("b2b_gap_last", aok_cyc_q[b+4] - aok_cyc_q[b+3], 32'd3);
    end

    // memory stalls address acceptance for 5 cycles
    addr_lat = 5; data_lat = 0; b = aok_cyc_q.size();
    t = mk(1, 1, 2'd1, 32'h8000_2000, 32'h1234_5678);
    exp_q.push_back(t); post(t);
    wait_idle(50);
    chk("stall_one_aok", aok_cyc_q.size() - b, 32'd1);

    // reset while a load waits for data; late data_ok must be ignored
    addr_lat = 0; data_lat = 20; b = aok_cyc_q.size(); nd = n_ddok;
    t = mk(1, 0, 2'd2, 32'h8000_3000, 32'd0);
    exp_q.push_back(t); post(t);
    for (int i = 0; i < 20 && aok_cyc_q.size() == b; i++) @(negedge clk);
    chk("rst_setup_aok", aok_cyc_q.size() - b, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    inj_n++;
    @(negedge clk);
    chk("late_dok_data", {31'b0, data_data_ok}, 32'd0);
    chk("late_dok_inst", {31'b0, inst_data_ok}, 32'd0);
    chk("late_dok_mem_req", {31'b0, mem_req}, 32'd0);
    data_lat = 0; ni = n_idok;
    t = mk(0, 0, 2'd2, 32'hBFC0_0200, 32'd0);
    exp_q.push_back(t); post(t);
    wait_idle(50);
    chk("post_rst_fetch", n_idok - ni, 32'd1);
    chk("post_rst_no_ddok", n_ddok - nd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
